// File: rtl/button_ce_conditioner_if.sv
// Pin-side bundle of the button conditioner: raw pin in, clean enable/level/debug state out.
interface button_ce_conditioner_if;
   logic       raw_i;
   logic       ce_o;
   logic       level_o;
   logic [1:0] state_o;

   modport master (output raw_i, input ce_o, level_o, state_o);
   modport slave  (input raw_i, output ce_o, level_o, state_o);
endinterface

// File: rtl/button_ce_conditioner.sv
// Synchronizes and debounces a raw button pin into single-cycle clock-enable pulses,
// with optional auto-repeat while the button is held.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | released; waiting for synchronized input to go high
// PRESS_CHK    | input high; must stay high DEBOUNCE_CYCLES to accept press
// HELD         | press accepted; initial pulse, then repeat pulses if enabled
// RELEASE_CHK  | input low; must stay low DEBOUNCE_CYCLES to accept release
module button_ce_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_EN       = 1,
   parameter int HOLD_CYCLES     = 64,
   parameter int REPEAT_CYCLES   = 16
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   button_ce_conditioner_if.slave    bus
);

   localparam int MAX_A   = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
   localparam int MAX_CYC = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
   localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

   localparam logic [CNT_W-1:0] DEB_LOAD  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_LOAD  = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      PRESS_CHK   = 2'd1,
      HELD        = 2'd2,
      RELEASE_CHK = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_t                 state_q, state_nxt;
   logic [CNT_W-1:0]       tmr_q, tmr_d;
   logic                   ce_q, ce_d;
   logic                   level_q, level_d;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) sync_q <= '0;
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.raw_i};
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Outputs are registered alongside the state so nothing combinational reaches the pins.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         ce_q    <= 1'b0;
         level_q <= 1'b0;
      end else begin
         state_q <= state_nxt;
         tmr_q   <= tmr_d;
         ce_q    <= ce_d;
         level_q <= level_d;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:        if (s) state_nxt = PRESS_CHK;
         PRESS_CHK:   if (!s) state_nxt = IDLE;
                      else if (tmr_q == '0) state_nxt = HELD;
         HELD:        if (!s) state_nxt = RELEASE_CHK;
         RELEASE_CHK: if (s) state_nxt = HELD;
                      else if (tmr_q == '0) state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   // One down-counter serves as debounce timer in the check states and repeat timer in HELD.
   always_comb begin
      tmr_d   = tmr_q;
      ce_d    = 1'b0;
      level_d = (state_nxt == HELD) || (state_nxt == RELEASE_CHK);
      case (state_q)
         IDLE: tmr_d = DEB_LOAD;
         PRESS_CHK: begin
            if (state_nxt == HELD) begin
               tmr_d = HOLD_LOAD;
               ce_d  = 1'b1;
            end else if (tmr_q != '0) begin
               tmr_d = tmr_q - CNT_ONE;
            end
         end
         HELD: begin
            if (state_nxt == RELEASE_CHK) begin
               tmr_d = DEB_LOAD;
            end else if (REPEAT_EN != 0) begin
               if (tmr_q == '0) begin
                  tmr_d = RPT_LOAD;
                  ce_d  = 1'b1;
               end else begin
                  tmr_d = tmr_q - CNT_ONE;
               end
            end
         end
         RELEASE_CHK: begin
            if (state_nxt == HELD)       tmr_d = RPT_LOAD;
            else if (state_nxt == IDLE)  tmr_d = DEB_LOAD;
            else if (tmr_q != '0)        tmr_d = tmr_q - CNT_ONE;
         end
         default: tmr_d = DEB_LOAD;
      endcase
   end

   assign bus.ce_o    = ce_q;
   assign bus.level_o = level_q;
   assign bus.state_o = state_q;

endmodule

// File: tb/tb_button_ce_conditioner.sv
// Directed bench: one conditioner without repeat, one with repeat, plus a small counter fed by ce_o.
module tb_button_ce_conditioner;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [7:0] ctr;

   button_ce_conditioner_if if0 ();
   button_ce_conditioner_if if1 ();

   button_ce_conditioner #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)
   ) dut0 (.clk_i(clk), .reset_i(rst), .bus(if0));

   button_ce_conditioner #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)
   ) dut1 (.clk_i(clk), .reset_i(rst), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           ctr <= 8'd0;
      else if (if0.ce_o) ctr <= ctr + 8'd1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_raw(input logic v);
      if0.raw_i = v;
      if1.raw_i = v;
   endtask

   task automatic idle(input int n);
      set_raw(1'b0);
      repeat (n) tick();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      set_raw(1'b0);
      tick();
      tick();
      n_checks++; if (if0.ce_o !== 1'b0)     begin n_fail++; $display("FAIL reset_ce0 got %b want 0", if0.ce_o); end
      n_checks++; if (if0.level_o !== 1'b0)  begin n_fail++; $display("FAIL reset_lvl0 got %b want 0", if0.level_o); end
      n_checks++; if (if0.state_o !== 2'd0)  begin n_fail++; $display("FAIL reset_st0 got %0d want 0", if0.state_o); end
      n_checks++; if (if1.ce_o !== 1'b0)     begin n_fail++; $display("FAIL reset_ce1 got %b want 0", if1.ce_o); end
      n_checks++; if (if1.level_o !== 1'b0)  begin n_fail++; $display("FAIL reset_lvl1 got %b want 0", if1.level_o); end
      n_checks++; if (if1.state_o !== 2'd0)  begin n_fail++; $display("FAIL reset_st1 got %0d want 0", if1.state_o); end
      rst = 1'b0;
      idle(4);
   endtask

   task automatic test_clean_press;
      int pulses = 0;
      logic exp_ce, exp_lvl;
      set_raw(1'b1);
      for (int e = 0; e <= 45; e++) begin
         tick();
         exp_ce  = (e == 6);
         exp_lvl = (e >= 6) && (e < 36);
         if (if0.ce_o) pulses++;
         n_checks++; if (if0.ce_o !== exp_ce)   begin n_fail++; $display("FAIL clean_ce edge %0d got %b want %b", e, if0.ce_o, exp_ce); end
         n_checks++; if (if0.level_o !== exp_lvl) begin n_fail++; $display("FAIL clean_lvl edge %0d got %b want %b", e, if0.level_o, exp_lvl); end
         if (e == 29) set_raw(1'b0);
      end
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL clean_pulses got %0d want 1", pulses); end
      idle(4);
   endtask

   task automatic test_bounce;
      logic [1:0] exp_st;
      set_raw(1'b1);
      for (int e = 0; e <= 14; e++) begin
         tick();
         exp_st = (e >= 2 && e <= 4) ? 2'd1 : 2'd0;
         n_checks++; if (if0.state_o !== exp_st) begin n_fail++; $display("FAIL bounce_st edge %0d got %0d want %0d", e, if0.state_o, exp_st); end
         n_checks++; if (if0.ce_o !== 1'b0)      begin n_fail++; $display("FAIL bounce_ce edge %0d got %b want 0", e, if0.ce_o); end
         n_checks++; if (if0.level_o !== 1'b0)   begin n_fail++; $display("FAIL bounce_lvl edge %0d got %b want 0", e, if0.level_o); end
         n_checks++; if (if1.ce_o !== 1'b0)      begin n_fail++; $display("FAIL bounce_ce1 edge %0d got %b want 0", e, if1.ce_o); end
         if (e == 2) set_raw(1'b0);
      end
      idle(4);
   endtask

   task automatic test_auto_repeat;
      logic       exp_ce, exp_lvl, prev_ce;
      logic [1:0] exp_st;
      int         pulses = 0;
      prev_ce = 1'b0;
      set_raw(1'b1);
      for (int e = 0; e <= 40; e++) begin
         tick();
         exp_ce  = (e == 6) || (e == 14) || (e == 18) || (e == 22) || (e == 26) || (e == 30);
         exp_lvl = (e >= 6) && (e < 36);
         if (e < 2)       exp_st = 2'd0;
         else if (e < 6)  exp_st = 2'd1;
         else if (e < 32) exp_st = 2'd2;
         else if (e < 36) exp_st = 2'd3;
         else             exp_st = 2'd0;
         if (if1.ce_o) pulses++;
         n_checks++; if (if1.ce_o !== exp_ce)     begin n_fail++; $display("FAIL rpt_ce edge %0d got %b want %b", e, if1.ce_o, exp_ce); end
         n_checks++; if (if1.level_o !== exp_lvl) begin n_fail++; $display("FAIL rpt_lvl edge %0d got %b want %b", e, if1.level_o, exp_lvl); end
         n_checks++; if (if1.state_o !== exp_st)  begin n_fail++; $display("FAIL rpt_st edge %0d got %0d want %0d", e, if1.state_o, exp_st); end
         n_checks++; if (prev_ce && if1.ce_o)     begin n_fail++; $display("FAIL rpt_back_to_back edge %0d got 1 want 0", e); end
         prev_ce = if1.ce_o;
         if (e == 29) set_raw(1'b0);
      end
      n_checks++; if (pulses !== 6) begin n_fail++; $display("FAIL rpt_pulses got %0d want 6", pulses); end
      idle(4);
   endtask

   task automatic test_release_glitch;
      logic [1:0] exp_st;
      set_raw(1'b1);
      for (int e = 0; e <= 24; e++) begin
         tick();
         n_checks++; if (if0.ce_o !== (e == 6)) begin n_fail++; $display("FAIL glitch_ce edge %0d got %b want %b", e, if0.ce_o, (e == 6)); end
         if (e >= 6) begin
            exp_st = (e == 13 || e == 14) ? 2'd3 : 2'd2;
            n_checks++; if (if0.state_o !== exp_st) begin n_fail++; $display("FAIL glitch_st edge %0d got %0d want %0d", e, if0.state_o, exp_st); end
            n_checks++; if (if0.level_o !== 1'b1)   begin n_fail++; $display("FAIL glitch_lvl edge %0d got %b want 1", e, if0.level_o); end
         end
         if (e == 10) set_raw(1'b0);
         if (e == 12) set_raw(1'b1);
      end
      idle(12);
      n_checks++; if (if0.state_o !== 2'd0) begin n_fail++; $display("FAIL glitch_end_st got %0d want 0", if0.state_o); end
      n_checks++; if (if0.level_o !== 1'b0) begin n_fail++; $display("FAIL glitch_end_lvl got %b want 0", if0.level_o); end
   endtask

   task automatic test_reset_mid_press;
      logic [1:0] exp_st;
      set_raw(1'b1);
      repeat (4) tick();
      n_checks++; if (if0.state_o !== 2'd1) begin n_fail++; $display("FAIL midrst_pre_st got %0d want 1", if0.state_o); end
      rst = 1'b1;
      #1;
      n_checks++; if (if0.state_o !== 2'd0) begin n_fail++; $display("FAIL midrst_st got %0d want 0", if0.state_o); end
      n_checks++; if (if0.ce_o !== 1'b0)    begin n_fail++; $display("FAIL midrst_ce got %b want 0", if0.ce_o); end
      n_checks++; if (if0.level_o !== 1'b0) begin n_fail++; $display("FAIL midrst_lvl got %b want 0", if0.level_o); end
      tick();
      rst = 1'b0;
      // same again, but from HELD where level_o is actually high
      set_raw(1'b1);
      repeat (8) tick();
      n_checks++; if (if0.level_o !== 1'b1) begin n_fail++; $display("FAIL heldrst_pre_lvl got %b want 1", if0.level_o); end
      rst = 1'b1;
      #1;
      n_checks++; if (if0.level_o !== 1'b0) begin n_fail++; $display("FAIL heldrst_lvl got %b want 0", if0.level_o); end
      n_checks++; if (if0.state_o !== 2'd0) begin n_fail++; $display("FAIL heldrst_st got %0d want 0", if0.state_o); end
      set_raw(1'b0);
      tick();
      rst = 1'b0;
      idle(4);
      set_raw(1'b1);
      for (int e = 0; e <= 10; e++) begin
         tick();
         exp_st = (e < 2) ? 2'd0 : (e < 6) ? 2'd1 : 2'd2;
         n_checks++; if (if0.ce_o !== (e == 6))    begin n_fail++; $display("FAIL fresh_ce edge %0d got %b want %b", e, if0.ce_o, (e == 6)); end
         n_checks++; if (if0.level_o !== (e >= 6)) begin n_fail++; $display("FAIL fresh_lvl edge %0d got %b want %b", e, if0.level_o, (e >= 6)); end
         n_checks++; if (if0.state_o !== exp_st)   begin n_fail++; $display("FAIL fresh_st edge %0d got %0d want %0d", e, if0.state_o, exp_st); end
      end
      idle(12);
   endtask

   task automatic test_counter_integration;
      logic [7:0] c0;
      int         pulses = 0;
      c0 = ctr;
      for (int p = 0; p < 3; p++) begin
         set_raw(1'b1);
         for (int i = 0; i < 12; i++) begin tick(); if (if0.ce_o) pulses++; end
         set_raw(1'b0);
         for (int i = 0; i < 12; i++) begin tick(); if (if0.ce_o) pulses++; end
      end
      n_checks++; if (pulses !== 3) begin n_fail++; $display("FAIL ctr_pulses got %0d want 3", pulses); end
      n_checks++; if (8'(ctr - c0) !== 8'd3) begin n_fail++; $display("FAIL ctr_delta got %0d want 3", 8'(ctr - c0)); end
   endtask

   initial begin
      rst = 1'b1;
      set_raw(1'b0);
      test_reset();
      test_clean_press();
      test_bounce();
      test_auto_repeat();
      test_release_glitch();
      test_reset_mid_press();
      test_counter_integration();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
